// File: rtl/ocp_slave_fsm.sv
// ocp_slave_fsm -- OCP slave with a 16-word register file and burst tracking.
//
// Ports:
//   Clk          in   OCP clock; all state changes on its rising edge
//   MReset_n     in   synchronous active-low reset (overrides EnableClk)
//   EnableClk    in   clock enable; 0 freezes all state and outputs
//   MCmd         in   OCP command (IDLE/WR/RD/RDEX/RDL/WRNP/WRC/BCST)
//   MAddr        in   byte address; word index is MAddr[5:2]
//   MData        in   write data
//   MBurstLength in   beats in the burst (0 treated as 1)
//   MReqLast     in   last request of a burst
//   SCmdAccept   out  request accepted this cycle (combinational)
//   SResp        out  response NULL/DVA/FAIL/ERR, one cycle after a request
//   SData        out  read data, valid when SResp=DVA
module ocp_slave_fsm #(
  parameter int MADDR_WIDTH = 64,
  parameter int MDATA_WIDTH = 8,
  parameter int SDATA_WIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   MReset_n,
  input  logic                   EnableClk,
  input  logic [2:0]             MCmd,
  input  logic [MADDR_WIDTH-1:0] MAddr,
  input  logic [MDATA_WIDTH-1:0] MData,
  input  logic [9:0]             MBurstLength,
  input  logic                   MReqLast,
  output logic                   SCmdAccept,
  output logic [1:0]             SResp,
  output logic [SDATA_WIDTH-1:0] SData
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_BURST = 2'd1,
    S_RD_BURST = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CMD_IDLE = 3'b000,
    CMD_WR   = 3'b001,
    CMD_RD   = 3'b010,
    CMD_RDEX = 3'b011,
    CMD_RDL  = 3'b100,
    CMD_WRNP = 3'b101,
    CMD_WRC  = 3'b110,
    CMD_BCST = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NULL = 2'b00,
    RESP_DVA  = 2'b01,
    RESP_FAIL = 2'b10,
    RESP_ERR  = 2'b11
  } resp_e;

  state_e                 state_q, state_d;
  logic [9:0]             cnt_q, cnt_d;
  cmd_e                   bcmd_q, bcmd_d;
  resp_e                  sresp_q, sresp_d;
  logic [SDATA_WIDTH-1:0] sdata_q, sdata_d;
  logic [MDATA_WIDTH-1:0] mem_q [16];

  cmd_e       cmd;
  logic       state_legal;
  logic       take;
  logic       beat;
  logic       in_range;
  logic       we;
  logic [3:0] idx;
  logic [9:0] eff_len;
  logic [9:0] load_cnt;

  assign cmd         = cmd_e'(MCmd);
  assign idx         = MAddr[5:2];
  assign in_range    = (MAddr[MADDR_WIDTH-1:6] == '0);
  assign state_legal = (state_q == S_IDLE) || (state_q == S_WR_BURST) ||
                       (state_q == S_RD_BURST);
  assign SCmdAccept  = EnableClk && MReset_n && state_legal;
  assign take        = SCmdAccept && (cmd != CMD_IDLE);
  assign eff_len     = (MBurstLength == 10'd0) ? 10'd1 : MBurstLength;
  assign load_cnt    = eff_len - 10'd1;

  assign SResp = sresp_q;
  assign SData = sdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcmd_d  = bcmd_q;
    sresp_d = RESP_NULL;
    sdata_d = '0;
    we      = 1'b0;
    beat    = 1'b0;

    if (!state_legal) begin
      state_d = S_IDLE;
    end else if (take) begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd == CMD_WR || cmd == CMD_WRNP || cmd == CMD_RD) begin
            beat   = 1'b1;
            cnt_d  = load_cnt;
            bcmd_d = cmd;
            if (load_cnt != 10'd0 && !MReqLast)
              state_d = (cmd == CMD_RD) ? S_RD_BURST : S_WR_BURST;
          end else begin
            sresp_d = RESP_ERR;
          end
        end
        S_WR_BURST, S_RD_BURST: begin
          // Only the command that opened the burst continues it; anything
          // else is rejected and abandons the burst.
          if (cmd == bcmd_q) begin
            beat  = 1'b1;
            cnt_d = cnt_q - 10'd1;
            if (MReqLast || cnt_q == 10'd1)
              state_d = S_IDLE;
          end else begin
            sresp_d = RESP_ERR;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // An out-of-range beat still counts toward the burst but touches
      // nothing and answers ERR.
      if (beat) begin
        if (!in_range) begin
          sresp_d = RESP_ERR;
        end else begin
          unique case (cmd)
            CMD_WR: we = 1'b1;
            CMD_WRNP: begin
              we      = 1'b1;
              sresp_d = RESP_DVA;
            end
            CMD_RD: begin
              sresp_d = RESP_DVA;
              sdata_d = mem_q[idx];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!MReset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcmd_q  <= CMD_IDLE;
      sresp_q <= RESP_NULL;
      sdata_q <= '0;
      for (int unsigned i = 0; i < 16; i++)
        mem_q[i] <= '0;
    end else if (EnableClk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcmd_q  <= bcmd_d;
      sresp_q <= sresp_d;
      sdata_q <= sdata_d;
      if (we)
        mem_q[idx] <= MData;
    end
  end

endmodule

// File: tb/tb_ocp_slave_fsm.sv
// tb_ocp_slave_fsm -- scoreboard bench for ocp_slave_fsm: directed scenarios
// followed by randomized traffic, checked against a transaction-level model.
module tb_ocp_slave_fsm;

  localparam bit [2:0] C_IDLE = 3'b000, C_WR = 3'b001, C_RD = 3'b010,
                       C_RDEX = 3'b011, C_RDL = 3'b100, C_WRNP = 3'b101,
                       C_WRC = 3'b110, C_BCST = 3'b111;
  localparam bit [1:0] R_NULL = 2'b00, R_DVA = 2'b01, R_ERR = 2'b11;

  logic        Clk = 1'b0;
  logic        MReset_n;
  logic        EnableClk;
  logic [2:0]  MCmd;
  logic [63:0] MAddr;
  logic [7:0]  MData;
  logic [9:0]  MBurstLength;
  logic        MReqLast;
  logic        SCmdAccept;
  logic [1:0]  SResp;
  logic [7:0]  SData;

  ocp_slave_fsm #(.MADDR_WIDTH(64), .MDATA_WIDTH(8), .SDATA_WIDTH(8)) dut (
    .Clk(Clk), .MReset_n(MReset_n), .EnableClk(EnableClk), .MCmd(MCmd),
    .MAddr(MAddr), .MData(MData), .MBurstLength(MBurstLength),
    .MReqLast(MReqLast), .SCmdAccept(SCmdAccept), .SResp(SResp), .SData(SData)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0] r;
    logic [7:0] d;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // Reference model: storage image plus an "open burst" descriptor.
  bit [7:0] m_mem [16];
  bit       m_open;
  bit [2:0] m_bcmd;
  int       m_left;
  bit [1:0] m_resp;
  bit [7:0] m_data;

  task automatic model_beat(input bit [2:0] c, input bit [63:0] a, input bit [7:0] d);
    if ((a >> 6) != 0) begin
      m_resp = R_ERR;
    end else if (c == C_WR) begin
      m_mem[a[5:2]] = d;
    end else if (c == C_WRNP) begin
      m_mem[a[5:2]] = d;
      m_resp = R_DVA;
    end else begin
      m_resp = R_DVA;
      m_data = m_mem[a[5:2]];
    end
  endtask

  task automatic model_step(input bit en, input bit rstn, input bit [2:0] c,
                            input bit [63:0] a, input bit [7:0] d,
                            input int len, input bit last);
    if (!rstn) begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_open = 0; m_resp = R_NULL; m_data = 8'h00;
    end else if (en) begin
      m_resp = R_NULL;
      m_data = 8'h00;
      if (c != C_IDLE) begin
        if (!m_open) begin
          if (c == C_WR || c == C_WRNP || c == C_RD) begin
            model_beat(c, a, d);
            m_left = ((len == 0) ? 1 : len) - 1;
            m_bcmd = c;
            m_open = (m_left > 0) && !last;
          end else begin
            m_resp = R_ERR;
          end
        end else if (c == m_bcmd) begin
          model_beat(c, a, d);
          m_left = m_left - 1;
          if (last || m_left == 0) m_open = 0;
        end else begin
          m_resp = R_ERR;
          m_open = 0;
        end
      end
    end
  endtask

  task automatic drive(input bit en, input bit rstn, input bit [2:0] c,
                       input bit [63:0] a, input bit [7:0] d, input int len,
                       input bit last, input string tag);
    exp_t e;
    EnableClk = en; MReset_n = rstn; MCmd = c; MAddr = a; MData = d;
    MBurstLength = len[9:0]; MReqLast = last;
    #1;
    n_vec++;
    if (SCmdAccept !== (en && rstn)) begin
      n_mis++;
      $display("FAIL %s accept: SCmdAccept=%b expected %b", tag, SCmdAccept, en && rstn);
    end
    model_step(en, rstn, c, a, d, len, last);
    @(posedge Clk);
    #1;
    e.r = m_resp; e.d = m_data; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic op(input bit [2:0] c, input bit [63:0] a, input bit [7:0] d = 8'h00,
                    input int len = 1, input bit last = 1'b1, input string tag = "op");
    drive(1'b1, 1'b1, c, a, d, len, last, tag);
  endtask

  // Monitor: each cycle's registered response is compared to the oldest
  // scoreboard entry.
  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (SResp !== e.r || SData !== e.d) begin
        n_mis++;
        $display("FAIL %s resp: SResp=%0d SData=%02h expected SResp=%0d SData=%02h",
                 e.tag, SResp, SData, e.r, e.d);
      end
    end
  end

  initial begin
    bit [63:0] a;
    bit [2:0]  c;
    int        r;

    drive(1'b1, 1'b0, C_IDLE, 64'h0, 8'h00, 1, 1'b1, "reset");
    drive(1'b0, 1'b0, C_WR, 64'h0, 8'h55, 1, 1'b1, "reset_noen");

    op(C_WR, 64'h0, 8'hFF, 1, 1'b1, "wr_ff");
    op(C_RD, 64'h0, 8'h00, 1, 1'b1, "rd_ff");
    op(C_IDLE, 64'h0, 8'h00, 1, 1'b1, "idle_after_rd");

    for (int i = 0; i < 4; i++) op(C_WR, 64'(i * 4), 8'(i), 4, i == 3, "wr_burst");
    for (int i = 0; i < 4; i++) op(C_RD, 64'(i * 4), 8'h00, 4, i == 3, "rd_burst");
    op(C_RDEX, 64'h0, 8'h00, 1, 1'b1, "after_burst_rdex");

    op(C_WRNP, 64'h40, 8'hAA, 1, 1'b1, "wrnp_oor");
    op(C_RDL, 64'h0, 8'h00, 1, 1'b1, "rdl");
    op(C_RD, 64'h0, 8'h00, 1, 1'b1, "rd_after_oor");
    op(C_WRNP, 64'h10, 8'h5A, 1, 1'b1, "wrnp_ok");
    op(C_RD, 64'h10, 8'h00, 1, 1'b1, "rd_wrnp");
    op(C_WRC, 64'h0, 8'h00, 1, 1'b1, "wrc");
    op(C_BCST, 64'h0, 8'h00, 1, 1'b1, "bcst");

    op(C_WR, 64'h0, 8'h11, 4, 1'b0, "gap_b1");
    op(C_WR, 64'h4, 8'h22, 4, 1'b0, "gap_b2");
    op(C_IDLE, 64'h0, 8'h00, 4, 1'b0, "gap_idle");
    op(C_RD, 64'h8, 8'h00, 4, 1'b0, "gap_rd_err");
    op(C_RD, 64'h8, 8'h00, 1, 1'b1, "gap_w2");
    op(C_RD, 64'hC, 8'h00, 1, 1'b1, "gap_w3");
    op(C_RD, 64'h0, 8'h00, 1, 1'b1, "gap_w0");

    op(C_RD, 64'h0, 8'h00, 4, 1'b0, "hold_rd1");
    op(C_RD, 64'h4, 8'h00, 4, 1'b0, "hold_rd2");
    drive(1'b0, 1'b1, C_RD, 64'h8, 8'h00, 4, 1'b0, "hold_en0a");
    drive(1'b0, 1'b1, C_WR, 64'h8, 8'h99, 4, 1'b0, "hold_en0b");
    op(C_RD, 64'h8, 8'h00, 4, 1'b0, "hold_rd3");
    drive(1'b0, 1'b0, C_RD, 64'hC, 8'h00, 4, 1'b1, "rst_mid");
    for (int i = 0; i < 16; i++) op(C_RD, 64'(i * 4), 8'h00, 1, 1'b1, "rd_cleared");

    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: c = C_IDLE;
        1, 2: c = C_WR;
        3, 4: c = C_RD;
        5: c = C_WRNP;
        default: c = 3'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 9) != 0) a = 64'($urandom_range(0, 63));
      else a = {32'($urandom), 32'($urandom)} | 64'h40;
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 49) != 0, c, a,
            8'($urandom), $urandom_range(0, 5), $urandom_range(0, 3) == 0, "random");
    end

    op(C_IDLE, 64'h0, 8'h00, 1, 1'b1, "drain");
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge Clk);
    @(negedge Clk);
    #1;
    if (sb.size() > 0) begin
      n_mis++;
      $display("FAIL drain: %0d responses unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/ocp_slave_fsm.md
OCP_SLAVE_FSM -- requirements
Module: ocp_slave_fsm

Interface
REQ-001 Parameter MADDR_WIDTH, default 64, width of the OCP address.
REQ-002 Parameter MDATA_WIDTH, default 8, width of the write data; SDATA_WIDTH, default 8, width of the read data; the two SHALL be equal.
REQ-003 Clk  input  1  OCP clock; one clock; all state SHALL change on its rising edge only.
REQ-004 MReset_n  input  1  reset; synchronous, active-low.
REQ-005 EnableClk  input  1  OCP clock enable; 0 = freeze.
REQ-006 MCmd  input  3  command: IDLE=000, WR=001, RD=010, RDEX=011, RDL=100, WRNP=101, WRC=110, BCST=111.
REQ-007 MAddr  input  MADDR_WIDTH  byte address; word index = MAddr[5:2].
REQ-008 MData  input  MDATA_WIDTH  write data.
REQ-009 MBurstLength  input  10  beats in the current burst; 0 SHALL be treated as 1.
REQ-010 MReqLast  input  1  marks the last request of a burst.
REQ-011 SCmdAccept  output  1  request accepted this cycle.
REQ-012 SResp  output  2  response: NULL=00, DVA=01, FAIL=10, ERR=11.
REQ-013 SData  output  SDATA_WIDTH  read data, valid when SResp=DVA.

Function
REQ-014 Storage SHALL be 16 words x MDATA_WIDTH, indexed by MAddr[5:2].
REQ-015 States SHALL be: IDLE, WR_BURST and RD_BURST.
REQ-016 SCmdAccept SHALL be combinational: 1 iff EnableClk=1, MReset_n=1 and the state is IDLE, WR_BURST or RD_BURST (the slave never stalls).
REQ-017 A request is taken on a rising edge with MCmd!=IDLE and SCmdAccept=1.
REQ-018 A request is in range iff MAddr[MADDR_WIDTH-1:6]=0; an out-of-range request SHALL not write storage and SHALL give SResp=ERR with SData=0 in the next cycle.
REQ-019 WR, in range: storage[MAddr[5:2]] SHALL be updated with MData at that edge. WR is posted, so SResp stays NULL.
REQ-020 WRNP, in range: same write as WR, plus SResp=DVA and SData=0 for the one cycle after each beat.
REQ-021 RD, in range: in the cycle after the request, SResp=DVA and SData=storage[MAddr[5:2]]; read latency is exactly 1 cycle.
REQ-022 Read-after-write to the same word on consecutive beats SHALL return the newly written data.
REQ-023 RDEX, RDL, WRC and BCST SHALL be accepted without any storage change and SHALL give SResp=ERR, SData=0 in the next cycle.
REQ-024 SResp SHALL return to NULL in the cycle after any one-cycle response unless a new request was taken; there is no response backpressure.
REQ-025 A 10-bit beat counter SHALL load effective MBurstLength-1 on the first beat of any WR, WRNP or RD.
REQ-026 IDLE -> WR_BURST (WR or WRNP) or RD_BURST (RD) when the loaded count is >0 and MReqLast=0; otherwise the state stays IDLE.
REQ-027 In a burst state, each taken beat of the same command SHALL be processed per REQ-019 to REQ-021 and SHALL decrement the counter.
REQ-028 The burst SHALL end (-> IDLE) on the beat where MReqLast=1 or the counter reaches 0, whichever comes first.
REQ-029 In a burst state, MCmd=IDLE SHALL hold the state and counter; no timeout.
REQ-030 In a burst state, a different non-IDLE command SHALL be accepted without a storage write, give SResp=ERR in the next cycle, and return the state to IDLE.
REQ-031 Each burst beat uses its own MAddr; the slave SHALL not generate addresses.
REQ-032 EnableClk=0: state, counter, storage, SResp and SData SHALL all hold.

Reset
REQ-033 MReset_n=0 at a rising edge SHALL give: state=IDLE, counter=0, SResp=NULL, SData=0, all 16 storage words=0.
REQ-034 While MReset_n=0, SCmdAccept SHALL be 0.
REQ-035 Reset during a burst SHALL abandon the burst with no further writes; reset SHALL override EnableClk.

Verification
REQ-036 Reset, then WR MAddr=0x0 MData=0xFF, then RD MAddr=0x0 -> SResp stays NULL after the WR; one cycle after the RD, SResp=DVA and SData=0xFF.
REQ-037 4-beat WR burst (MBurstLength=4), addresses 0x0/0x4/0x8/0xC, data 0..3, MReqLast on beat 4, then 4-beat RD burst on the same addresses -> reads return 0,1,2,3 each one cycle after its request; state is IDLE after each burst.
REQ-038 WRNP MAddr=0x40 -> next cycle SResp=ERR, storage unchanged; RDL MAddr=0x0 -> SResp=ERR, SData=0.
REQ-039 WR burst of length 4 with MCmd=IDLE inserted after beat 2, then a RD as beat 3 -> SResp=ERR, state IDLE, words 2 and 3 unwritten.
REQ-040 EnableClk=0 mid read burst -> SResp/SData held and SCmdAccept=0; MReset_n=0 mid burst -> next cycle SResp=NULL and all storage reads back 0.
